mm_ctrl: RTL and testbench

Matrix-multiply engine that consumes the descriptor latched by the CPU-side descriptor register block: dim, A, B and C base addresses plus a start pulse. It fetches the dimension word and then the A and B operands from data memory, one word per access. It accumulates each dot product and writes every C element back. It signals completion to the CPU pipeline with busy/done/err.

---
 rtl/mm_pkg.sv | 23 ++
 rtl/mm_mac.sv | 38 +++
 rtl/mm_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mm_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-multiply engine: FSM states,
// dimension-word field layout and the element stride in bytes.
package mm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_DIM,
        WAIT_DIM,
        RD_A,
        RD_B,
        MAC,
        WR_C,
        DONE
    } state_t;

    localparam int DIM_FW      = 8;
    localparam int DIM_M_LSB   = 0;
    localparam int DIM_K_LSB   = 8;
    localparam int DIM_N_LSB   = 16;
    localparam int MAX_DIM_DEF = 8;
    localparam int WORD_BYTES  = 4;

endpackage

// File: rtl/mm_mac.sv
// Multiply-accumulate register for one dot product. sum is the wrapped
// acc + a*b and is exposed so the caller can write the final value out directly.
module mm_mac
    import mm_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [DW-1:0] sum
);

    logic signed [DW-1:0] acc_p0;

    // The DW-bit context truncates the product and sum to two's-complement wrap.
    function automatic logic signed [DW-1:0] mac_wrap(input logic signed [DW-1:0] acc,
                                                      input logic signed [DW-1:0] x,
                                                      input logic signed [DW-1:0] y);
        return acc + x * y;
    endfunction

    assign sum = mac_wrap(acc_p0, a, b);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_p0 <= '0;
        end else if (clr) begin
            acc_p0 <= '0;
        end else if (en) begin
            acc_p0 <= sum;
        end
    end

endmodule

// File: rtl/mm_ctrl.sv
// Matrix-multiply controller: fetches the dimension word and the A/B operands
// one word at a time, accumulates each dot product and writes C back.
module mm_ctrl
    import mm_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int MAX_DIM = MAX_DIM_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] dim_addr,
    input  logic [AW-1:0] a_addr,
    input  logic [AW-1:0] b_addr,
    input  logic [AW-1:0] c_addr,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_wdata
);

    localparam logic [DIM_FW-1:0] MAX_F = DIM_FW'(MAX_DIM);
    localparam logic [DIM_FW-1:0] ONE_F = DIM_FW'(1);

    state_t               state;
    logic [AW-1:0]        a_base, b_base, c_base;
    logic [DIM_FW-1:0]    m_dim, k_dim, n_dim;
    logic [DIM_FW-1:0]    i_idx, j_idx, k_idx;
    logic signed [DW-1:0] a_p0;
    logic signed [DW-1:0] mac_sum;
    logic [DIM_FW-1:0]    fld_m, fld_k, fld_n, i_next;
    logic                 dim_bad, k_last, j_last, i_last;
    logic                 mac_clr, mac_en;

    function automatic logic [AW-1:0] elem_addr(input logic [AW-1:0]     base,
                                                input logic [DIM_FW-1:0] row,
                                                input logic [DIM_FW-1:0] cols,
                                                input logic [DIM_FW-1:0] col);
        return base + AW'(WORD_BYTES) * (AW'(row) * AW'(cols) + AW'(col));
    endfunction

    assign fld_m   = mem_rdata[DIM_M_LSB +: DIM_FW];
    assign fld_k   = mem_rdata[DIM_K_LSB +: DIM_FW];
    assign fld_n   = mem_rdata[DIM_N_LSB +: DIM_FW];
    assign dim_bad = (fld_m == '0) || (fld_m > MAX_F) ||
                     (fld_k == '0) || (fld_k > MAX_F) ||
                     (fld_n == '0) || (fld_n > MAX_F);
    assign k_last  = (k_idx == k_dim - ONE_F);
    assign j_last  = (j_idx == n_dim - ONE_F);
    assign i_last  = (i_idx == m_dim - ONE_F);
    assign i_next  = j_last ? i_idx + ONE_F : i_idx;
    assign mac_clr = (state == WAIT_DIM) || (state == WR_C);
    assign mac_en  = (state == MAC);

    mm_mac #(.DW(DW)) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (a_p0),
        .b     ($signed(mem_rdata)),
        .sum   (mac_sum)
    );

    // Outputs are registered: each branch sets the strobes for the state it enters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            a_base    <= '0;
            b_base    <= '0;
            c_base    <= '0;
            m_dim     <= '0;
            k_dim     <= '0;
            n_dim     <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            k_idx     <= '0;
            a_p0      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_base    <= a_addr;
                        b_base    <= b_addr;
                        c_base    <= c_addr;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= dim_addr;
                        state     <= FETCH_DIM;
                    end
                end
                FETCH_DIM: begin
                    mem_rd_en <= 1'b0;
                    state     <= WAIT_DIM;
                end
                WAIT_DIM: begin
                    m_dim <= fld_m;
                    k_dim <= fld_k;
                    n_dim <= fld_n;
                    if (dim_bad) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        i_idx     <= '0;
                        j_idx     <= '0;
                        k_idx     <= '0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= a_base;
                        state     <= RD_A;
                    end
                end
                RD_A: begin
                    mem_addr <= elem_addr(b_base, k_idx, n_dim, j_idx);
                    state    <= RD_B;
                end
                RD_B: begin
                    a_p0      <= mem_rdata;
                    mem_rd_en <= 1'b0;
                    state     <= MAC;
                end
                MAC: begin
                    if (k_last) begin
                        mem_wr_en <= 1'b1;
                        mem_addr  <= elem_addr(c_base, i_idx, n_dim, j_idx);
                        mem_wdata <= mac_sum;
                        state     <= WR_C;
                    end else begin
                        k_idx     <= k_idx + ONE_F;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= elem_addr(a_base, i_idx, k_dim, k_idx + ONE_F);
                        state     <= RD_A;
                    end
                end
                WR_C: begin
                    mem_wr_en <= 1'b0;
                    k_idx     <= '0;
                    i_idx     <= i_next;
                    j_idx     <= j_last ? '0 : j_idx + ONE_F;
                    if (i_last && j_last) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= elem_addr(a_base, i_next, k_dim, '0);
                        state     <= RD_A;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_ctrl.sv
// Scoreboard bench for mm_ctrl: a behavioural matrix-multiply model queues
// expected C writes and completion cycles; a monitor checks them as they appear.
module tb_mm_ctrl;

    localparam int P = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dim_addr, a_addr, b_addr, c_addr;
    logic        busy, done, err;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata = '0;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;

    always #(P/2) clk = ~clk;

    mm_ctrl #(.DW(32), .AW(32), .MAX_DIM(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dim_addr  (dim_addr),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .c_addr    (c_addr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata)
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int cyc; logic err; } dn_t;

    wr_t         exp_wr_q[$];
    dn_t         exp_dn_q[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] A_v [64];
    logic [31:0] B_v [64];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (mem_rd_en) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;

    always @(negedge clk) begin : monitor
        wr_t w;
        dn_t d;
        if (reset) begin
            if (mem_rd_en || mem_wr_en) begin
                checks++;
                if (mem_rd_en && mem_wr_en) begin
                    errors++;
                    $display("FAIL strobe_excl rd_en=%b wr_en=%b required not both", mem_rd_en, mem_wr_en);
                end
            end
            if (mem_wr_en) begin
                mem[mem_addr] = mem_wdata;
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%h data=%h required no write", mem_addr, mem_wdata);
                end else begin
                    w = exp_wr_q.pop_front();
                    if (mem_addr !== w.addr || mem_wdata !== w.data) begin
                        errors++;
                        $display("FAIL c_write got addr=%h data=%h required addr=%h data=%h",
                                 mem_addr, mem_wdata, w.addr, w.data);
                    end
                end
            end
            if (done) begin
                checks++;
                if (exp_dn_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cycle=%0d required no done", cyc);
                end else begin
                    d = exp_dn_q.pop_front();
                    if (cyc != d.cyc || err !== d.err || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL done_event got cyc=%0d err=%b busy=%b required cyc=%0d err=%b busy=1",
                                 cyc, err, busy, d.cyc, d.err);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, expv);
        end
    endtask

    // Reference model: plain triple loop over the matrices held in A_v/B_v.
    task automatic issue(input logic [31:0] dimw, input logic [31:0] da, input logic [31:0] aa,
                         input logic [31:0] ba, input logic [31:0] ca);
        int          mi, ki, ni;
        logic [31:0] acc;
        wr_t         w;
        dn_t         d;
        mi = int'(dimw[7:0]);
        ki = int'(dimw[15:8]);
        ni = int'(dimw[23:16]);
        mem[da] = dimw;
        @(negedge clk);
        if (mi == 0 || ki == 0 || ni == 0 || mi > 8 || ki > 8 || ni > 8) begin
            d.cyc = cyc + 3;
            d.err = 1'b1;
        end else begin
            for (int i = 0; i < mi; i++)
                for (int k = 0; k < ki; k++)
                    mem[aa + 32'(4 * (i * ki + k))] = A_v[i * ki + k];
            for (int k = 0; k < ki; k++)
                for (int j = 0; j < ni; j++)
                    mem[ba + 32'(4 * (k * ni + j))] = B_v[k * ni + j];
            for (int i = 0; i < mi; i++)
                for (int j = 0; j < ni; j++) begin
                    acc = 32'h0;
                    for (int k = 0; k < ki; k++)
                        acc = acc + A_v[i * ki + k] * B_v[k * ni + j];
                    w.addr = ca + 32'(4 * (i * ni + j));
                    w.data = acc;
                    exp_wr_q.push_back(w);
                end
            d.cyc = cyc + 2 + mi * ni * (3 * ki + 1) + 1;
            d.err = 1'b0;
        end
        exp_dn_q.push_back(d);
        dim_addr = da;
        a_addr   = aa;
        b_addr   = ba;
        c_addr   = ca;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (exp_dn_q.size() != 0 && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        checks++;
        if (exp_dn_q.size() != 0) begin
            errors++;
            $display("FAIL done_timeout pending=%0d required 0 within %0d cycles", exp_dn_q.size(), budget);
            exp_dn_q.delete();
        end
        checks++;
        if (exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes pending=%0d required 0", exp_wr_q.size());
            exp_wr_q.delete();
        end
    endtask

    task automatic set_vals(input logic [31:0] a0, a1, a2, a3, a4, a5,
                            input logic [31:0] b0, b1, b2, b3, b4, b5);
        A_v[0] = a0; A_v[1] = a1; A_v[2] = a2; A_v[3] = a3; A_v[4] = a4; A_v[5] = a5;
        B_v[0] = b0; B_v[1] = b1; B_v[2] = b2; B_v[3] = b3; B_v[4] = b4; B_v[5] = b5;
    endtask

    initial begin : watchdog
        #(P * 90000);
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] rm, rk, rn;
        reset = 1'b0; start = 1'b0;
        dim_addr = '0; a_addr = '0; b_addr = '0; c_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_rd_en", {31'b0, mem_rd_en}, 32'h0);
        chk("rst_wr_en", {31'b0, mem_wr_en}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // 2x2x2 and 2x3x2 directed products
        set_vals(1, 2, 3, 4, 0, 0, 5, 6, 7, 8, 0, 0);
        issue(32'h00_02_02_02, 32'h100, 32'h1000, 32'h2000, 32'h3000);
        wait_done(200);
        set_vals(1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12);
        issue(32'h00_02_03_02, 32'h104, 32'h1100, 32'h2100, 32'h3100);
        wait_done(200);

        // 1x1x1 wrap
        set_vals(32'hFFFF_FFFF, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        issue(32'hA5_01_01_01, 32'h108, 32'h1200, 32'h2200, 32'h3200);
        wait_done(50);

        // C base that wraps past the top of the address space
        set_vals(3, 0, 0, 0, 0, 0, 5, 7, 0, 0, 0, 0);
        issue(32'h00_02_01_01, 32'h10C, 32'h1300, 32'h2300, 32'hFFFF_FFFC);
        wait_done(50);

        // illegal dimensions: K=0, then M=9; a legal start then clears err
        issue(32'h00_02_00_02, 32'h110, 32'h1400, 32'h2400, 32'h3400);
        wait_done(50);
        @(negedge clk);
        chk("err_hold_k0", {31'b0, err}, 32'h1);
        chk("idle_busy_k0", {31'b0, busy}, 32'h0);
        issue(32'h00_01_01_09, 32'h114, 32'h1400, 32'h2400, 32'h3400);
        wait_done(50);
        @(negedge clk);
        chk("err_hold_m9", {31'b0, err}, 32'h1);
        set_vals(6, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
        issue(32'h00_01_01_01, 32'h118, 32'h1500, 32'h2500, 32'h3500);
        chk("err_cleared", {31'b0, err}, 32'h0);
        wait_done(50);

        // start during RD_B of a running job is ignored
        set_vals(2, 3, 4, 5, 0, 0, 6, 7, 8, 9, 0, 0);
        issue(32'h00_02_02_02, 32'h11C, 32'h1600, 32'h2600, 32'h3600);
        repeat (3) @(negedge clk);
        dim_addr = 32'h180; a_addr = 32'h1700; b_addr = 32'h2700; c_addr = 32'h3700;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200);

        // asynchronous reset in the middle of a MAC cycle
        set_vals(1, 2, 3, 4, 0, 0, 5, 6, 7, 8, 0, 0);
        issue(32'h00_02_02_02, 32'h120, 32'h1800, 32'h2800, 32'h3800);
        repeat (4) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_done", {31'b0, done}, 32'h0);
        chk("arst_err", {31'b0, err}, 32'h0);
        chk("arst_rd_en", {31'b0, mem_rd_en}, 32'h0);
        chk("arst_wr_en", {31'b0, mem_wr_en}, 32'h0);
        chk("arst_addr", mem_addr, 32'h0);
        chk("arst_wdata", mem_wdata, 32'h0);
        exp_wr_q.delete();
        exp_dn_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", {31'b0, busy}, 32'h0);
        chk("post_rst_rd_en", {31'b0, mem_rd_en}, 32'h0);
        set_vals(9, 0, 0, 0, 0, 0, 11, 0, 0, 0, 0, 0);
        issue(32'h00_01_01_01, 32'h124, 32'h1900, 32'h2900, 32'h3900);
        wait_done(50);

        // randomized legal jobs
        for (int r = 0; r < 8; r++) begin
            rm = 8'($urandom_range(1, 4));
            rk = 8'($urandom_range(1, 4));
            rn = 8'($urandom_range(1, 4));
            for (int x = 0; x < 64; x++) begin
                A_v[x] = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 20));
                B_v[x] = (r % 3 == 0) ? $urandom : 32'($urandom_range(0, 20));
            end
            issue({8'($urandom), rn, rk, rm},
                  32'h140 + 32'(4 * $urandom_range(0, 15)),
                  32'h4000 + 32'(4 * $urandom_range(0, 255)),
                  32'h5000 + 32'(4 * $urandom_range(0, 255)),
                  32'h6000 + 32'(4 * $urandom_range(0, 255)));
            wait_done(400);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
